// File: rtl/keypad_matrix_emulator.sv
// Emulated 4x4 keypad: presses one key on command, with LFSR-driven contact bounce.
// Optional feature macro KEYPAD_EMU_BOUNCE_EN enables the make/break bounce windows.
module keypad_matrix_emulator #(
    parameter int          BOUNCE_CYCLES = 64,
    parameter int          HOLD_W        = 16,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        row,
    output logic [3:0]        col,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        key_code,
    input  logic [HOLD_W-1:0] hold_cycles,
    output logic              busy,
    output logic              done,
    output logic [7:0]        scan_hits
);

    localparam logic [2:0] IDLE         = 3'd0;
    localparam logic [2:0] MAKE_BOUNCE  = 3'd1;
    localparam logic [2:0] HOLD         = 3'd2;
    localparam logic [2:0] BREAK_BOUNCE = 3'd3;
    localparam logic [2:0] RELEASE      = 3'd4;

    if (BOUNCE_CYCLES < 1) begin : g_bad_bounce
        $error("BOUNCE_CYCLES must be at least 1");
    end
    if (LFSR_SEED == 16'h0000) begin : g_bad_seed
        $error("LFSR_SEED must be nonzero");
    end

    // Returns {row, col} of a hex key on the physical keypad layout.
    function automatic logic [3:0] key_pos(input logic [3:0] k);
        case (k)
            4'h1:    key_pos = {2'd0, 2'd0};
            4'h2:    key_pos = {2'd0, 2'd1};
            4'h3:    key_pos = {2'd0, 2'd2};
            4'hA:    key_pos = {2'd0, 2'd3};
            4'h4:    key_pos = {2'd1, 2'd0};
            4'h5:    key_pos = {2'd1, 2'd1};
            4'h6:    key_pos = {2'd1, 2'd2};
            4'hB:    key_pos = {2'd1, 2'd3};
            4'h7:    key_pos = {2'd2, 2'd0};
            4'h8:    key_pos = {2'd2, 2'd1};
            4'h9:    key_pos = {2'd2, 2'd2};
            4'hC:    key_pos = {2'd2, 2'd3};
            4'hE:    key_pos = {2'd3, 2'd0};
            4'h0:    key_pos = {2'd3, 2'd1};
            4'hF:    key_pos = {2'd3, 2'd2};
            default: key_pos = {2'd3, 2'd3};
        endcase
    endfunction

    logic [2:0]        state_reg, state_next;
    logic [1:0]        key_row_reg, key_col_reg;
    logic [HOLD_W-1:0] hold_cnt_reg;
    logic              row_q_reg;
    logic [7:0]        scan_hits_reg;
    logic              accept, contact, bounce_last, hold_last, row_bit;
    logic [3:0]        key_pos_in;
    logic [1:0]        sel_row;

    assign accept     = cmd_valid && cmd_ready;
    assign key_pos_in = key_pos(key_code);
    assign hold_last  = (state_reg == HOLD) && (hold_cnt_reg == HOLD_W'(1));
    assign row_bit    = row[key_row_reg];

`ifdef KEYPAD_EMU_BOUNCE_EN
    localparam int               CNT_W       = $clog2(BOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] BOUNCE_LAST = CNT_W'(BOUNCE_CYCLES - 1);
    localparam logic [2:0]       AFTER_IDLE  = MAKE_BOUNCE;
    localparam logic [2:0]       AFTER_HOLD  = BREAK_BOUNCE;

    logic [CNT_W-1:0] bounce_cnt_reg;
    logic [15:0]      lfsr_reg;
    logic             in_bounce;

    assign in_bounce   = (state_reg == MAKE_BOUNCE) || (state_reg == BREAK_BOUNCE);
    assign bounce_last = (bounce_cnt_reg == '0);
    assign contact     = (state_reg == HOLD) || (in_bounce && lfsr_reg[0]);

    // The LFSR free-runs across presses so each press bounces differently.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bounce_cnt_reg <= '0;
            lfsr_reg       <= LFSR_SEED;
        end else begin
            if (accept || hold_last)
                bounce_cnt_reg <= BOUNCE_LAST;
            else if (in_bounce)
                bounce_cnt_reg <= bounce_cnt_reg - CNT_W'(1);
            if (in_bounce)
                lfsr_reg <= {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? 16'hB400 : 16'h0000);
        end
    end
`else
    localparam logic [2:0] AFTER_IDLE = HOLD;
    localparam logic [2:0] AFTER_HOLD = RELEASE;

    assign bounce_last = 1'b1;
    assign contact     = (state_reg == HOLD);
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:         if (accept) state_next = AFTER_IDLE;
            MAKE_BOUNCE:  if (bounce_last) state_next = HOLD;
            HOLD:         if (hold_last) state_next = AFTER_HOLD;
            BREAK_BOUNCE: if (bounce_last) state_next = RELEASE;
            RELEASE:      state_next = IDLE;
            default:      state_next = IDLE;
        endcase
    end

    // On accept, track the new key's row so the first pressed cycle sees a valid history.
    assign sel_row = accept ? key_pos_in[3:2] : key_row_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            key_row_reg   <= 2'd0;
            key_col_reg   <= 2'd0;
            hold_cnt_reg  <= HOLD_W'(1);
            row_q_reg     <= 1'b0;
            scan_hits_reg <= 8'd0;
        end else begin
            state_reg <= state_next;
            row_q_reg <= row[sel_row];
            if (accept) begin
                key_row_reg   <= key_pos_in[3:2];
                key_col_reg   <= key_pos_in[1:0];
                hold_cnt_reg  <= (hold_cycles == '0) ? HOLD_W'(1) : hold_cycles;
                scan_hits_reg <= 8'd0;
            end else begin
                if (state_reg == HOLD)
                    hold_cnt_reg <= hold_cnt_reg - HOLD_W'(1);
                if (contact && row_bit && !row_q_reg && (scan_hits_reg != 8'hFF))
                    scan_hits_reg <= scan_hits_reg + 8'd1;
            end
        end
    end

    assign col       = (contact && row_bit) ? (4'b0001 << key_col_reg) : 4'b0000;
    assign cmd_ready = (state_reg == IDLE);
    assign busy      = !cmd_ready;
    assign done      = (state_reg == RELEASE);
    assign scan_hits = scan_hits_reg;

endmodule

// File: doc/keypad_matrix_emulator.md
Name: keypad_matrix_emulator

Overview:
- Synthesizable stand-in for the physical 4x4 keypad; the scanner side of the keypad interface drives rows, and this block answers on the columns.
- Used for on-FPGA self-test and in benches against keypad_handler.
- Accepts a "press key K for N cycles" command, then closes the matching row/column contact with programmable contact bounce on make and on break.

Parameters:
- BOUNCE_CYCLES, 64: length of each bounce window (make and break), in clk cycles.
- HOLD_W, 16: width of the hold-duration command field.
- LFSR_SEED, 16'hACE1: nonzero seed for the bounce pattern LFSR.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- row  in  4  row drive from the scanner; active-high; one-hot or zero expected.
- col  out  4  column response; active-high; 0 when no contact.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  high only in IDLE.
- key_code  in  4  hex key to press, 0x0-0xF.
- hold_cycles  in  HOLD_W  cycles of solid contact after the make bounce.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on return to IDLE.
- scan_hits  out  8  count of rising edges of row[key_row] seen while contact is closed; saturates at 255.

Behaviour:
- Key map, fixed (row,col):
  - 1=(0,0), 2=(0,1), 3=(0,2), A=(0,3)
  - 4=(1,0), 5=(1,1), 6=(1,2), B=(1,3)
  - 7=(2,0), 8=(2,1), 9=(2,2), C=(2,3)
  - E=(3,0), 0=(3,1), F=(3,2), D=(3,3)
- Contact path: col = contact ? (row[key_row] ? onehot(key_col) : 4'b0) : 4'b0. This is combinational from row, like a real switch. If several rows are driven, only key_row matters.
- Reset (asynchronous, active-low):
  - state=IDLE, contact=0, col=0, cmd_ready=1, busy=0, done=0, scan_hits=0, LFSR=LFSR_SEED.
  - Reset mid-press opens the contact immediately.
- Command accept: a handshake occurs when cmd_valid && cmd_ready at a clk edge.
  - On that edge, key_code and hold_cycles are latched; a latched hold_cycles of 0 is treated as 1.
  - scan_hits clears to 0 on the same edge.
  - cmd_valid while busy is ignored; no queueing.
- FSM:
  - IDLE -> MAKE_BOUNCE on accept.
  - MAKE_BOUNCE: lasts BOUNCE_CYCLES cycles; contact = LFSR bit 0, LFSR advances each cycle. Exits to HOLD.
  - HOLD: contact=1 for exactly hold_cycles cycles. Exits to BREAK_BOUNCE.
  - BREAK_BOUNCE: lasts BOUNCE_CYCLES cycles; contact = LFSR bit 0. Exits to RELEASE.
  - RELEASE: contact=0 for 1 cycle, done=1 on this cycle. Then IDLE.
- Latency: accept edge to first cycle of solid contact is BOUNCE_CYCLES+1 cycles. Accept to done is 2*BOUNCE_CYCLES + hold + 1 cycles.
- LFSR: 16-bit Galois, taps 16,14,13,11. It is not reset between commands, so the bounce pattern differs per press.
- Edge counting: row[key_row] is registered once; a rising edge counts when contact=1 in that cycle. scan_hits holds its value after done until the next accept.
- busy = !cmd_ready.

Optional Feature:
- KEYPAD_EMU_BOUNCE_EN
- Defined: MAKE_BOUNCE and BREAK_BOUNCE behave as above.
- Undefined: both bounce states are bypassed (IDLE -> HOLD -> RELEASE). The LFSR is not instantiated. Accept-to-done latency = hold + 1 cycles.

Test Plan:
- Reset: assert reset=0 mid-HOLD with row=4'b0010, key=5 -> col=0 and busy=0 asynchronously; cmd_ready=1 after reset release.
- Clean press (macro off): key=0x8, hold=10, row=4'b0100 held -> col=4'b0010 for exactly 10 cycles; done pulses 11 cycles after accept.
- Row gating: key=0xD, hold=20, row rotating one-hot every 2 cycles -> col=4'b1000 only while row=4'b1000, else 0; scan_hits equals the number of row[3] rising edges during HOLD.
- Bounce (macro on, BOUNCE_CYCLES=8): key=0x1, hold=4, row=4'b0001 -> col[0] follows the LFSR for 8 cycles, solid 1 for 4 cycles, LFSR for 8 cycles; done 21 cycles after accept.
- Handshake: cmd_valid held high with key=0x3 then 0xA while busy -> only 0x3 is pressed; 0xA is accepted on the first IDLE cycle after done.
- Boundary: hold=0 -> treated as 1 cycle of contact; scan_hits saturates at 255 with hold=1000 and row[key_row] toggling every cycle.
